vip_sobel_frame_ctrl: RTL and testbench
=======================================

// Module: vip_sobel_frame_ctrl
// PURPOSE
//  Frame-synchronous run controller for the Sobel edge-detector path.
//  Sits between the CMOS capture stream and the detector: gates whole frames into it,
//  holds the runtime edge threshold, applies config only on frame boundaries,
//  and counts edge pixels per output frame.
//  Host side is a simple single-cycle register port.
// PARAMETERS
//  THRESH_DEFAULT  128  threshold value after reset (11-bit)
//  CNT_W           24   width of edge-pixel counters (>= log2(pixels/frame)+1)
//  FCNT_W          16   width of passed-frame counter
// PORTS
//  clk               in   1       pixel clock
//  rst_n             in   1       async active-low reset
//  cfg_wr_en         in   1       register write strobe, one cycle
//  cfg_addr          in   2       register address
//  cfg_wdata         in   32      write data
//  cfg_rdata         out  32      read data, combinational on cfg_addr
//  per_frame_vsync   in   1       camera vsync, active high, rises at frame start
//  per_frame_href    in   1       camera line valid
//  per_frame_clken   in   1       camera pixel strobe
//  det_frame_vsync   out  1       gated vsync to detector
//  det_frame_href    out  1       gated href to detector
//  det_frame_clken   out  1       gated clken to detector
//  det_threshold     out  11      active threshold to detector magnitude compare
//  post_frame_vsync  in   1       detector output vsync
//  post_frame_href   in   1       detector output href
//  post_frame_clken  in   1       detector output pixel strobe
//  post_img_bit      in   1       detector edge bit
//  frame_done        out  1       1-cycle pulse, edge_count_last updated
//  busy              out  1       high in ARM, RUN, STOP_PEND
// BEHAVIOUR
//  Registers:
//   - 0 CTRL    RW  [0]=enable, [1]=single_shot
//   - 1 THRESH  RW  [10:0] shadow threshold
//   - 2 STATUS  RO  [1:0]=state, [31:16]=frame_cnt
//   - 3 EDGES   RO  edge_count_last, zero-extended
//  Reset: all det_* 0, det_threshold=THRESH_DEFAULT, shadow=THRESH_DEFAULT, CTRL=0,
//   counters 0, frame_done 0, busy 0, state IDLE.
//  vs_rise = per_frame_vsync & ~vs_q (vs_q = input registered once).
//  gate_nxt = gate open for the frame that vs_rise starts.
//  det_* <= per_* & gate_nxt; detector inputs lag the camera by 1 cycle.
//  FSM:
//   - IDLE: gate closed. enable=1 -> ARM.
//   - ARM: gate closed. vs_rise -> RUN, gate opens this same cycle.
//   - RUN: gate open.
//     - vs_rise with enable=0 -> IDLE, gate closes at that boundary.
//     - single_shot=1 with the frame complete (next vs_rise) -> IDLE and hw clears CTRL[0].
//     - enable cleared mid-frame -> STOP_PEND.
//   - STOP_PEND: gate open. vs_rise -> IDLE (gate closed from that cycle).
//     enable re-set before vs_rise -> back to RUN.
//  Gate never opens or closes except on vs_rise; the detector never sees a partial frame.
//  det_threshold <= shadow on every vs_rise that opens or keeps gate open.
//  A THRESH write in the same cycle as vs_rise applies at that boundary (write data forwarded).
//  frame_cnt increments on each vs_rise that opens or keeps gate open; wraps at 2^FCNT_W.
//  Edge counting, post side:
//   - edge_acc++ when post_frame_clken & post_frame_href & post_img_bit.
//   - On post vsync rise: edge_count_last <= edge_acc (including a hit in that cycle),
//     edge_acc <= 0, frame_done=1. Suppressed when edge_acc==0 and no frame passed since reset.
//   - edge_acc saturates at all-ones; it does not wrap.
//  Writes to RO addresses are ignored.
//  Async reset mid-frame forces IDLE immediately and zeros det_* outputs.
// STRUCTURE
//  Package vip_sobel_pkg:
//   - state typedef {IDLE=0, ARM=1, RUN=2, STOP_PEND=3}
//   - register address constants
//   - THRESH_W=11
//  One sub-module: vip_edge_counter (post-side edge detection, saturating accumulate,
//   latch and pulse). FSM, gate and register file stay in top.
// TESTING
//  - Reset, read all regs -> THRESH=128, STATUS=0, EDGES=0; det_* low with camera toggling.
//  - enable=1 mid-frame -> det_* stay 0 until next vsync rise, then mirror camera 1 cycle late;
//    state=RUN, frame_cnt=1.
//  - THRESH=200 written mid-frame -> det_threshold stays 128 until next vsync rise, then 200.
//    Write coincident with vs_rise -> 200 at that boundary.
//  - Clear enable mid-frame -> STOP_PEND; gated stream continues to frame end, closes at vs_rise.
//    Re-enable before vs_rise -> stays RUN, no gap.
//  - single_shot=1 + enable=1 -> exactly one frame passed; CTRL[0] reads 0; frame_cnt +1.
//  - Inject 37 edge bits in a post frame -> next post vsync rise: frame_done pulse, EDGES=37.
//    Continuous hits on a CNT_W=4 build -> EDGES=15 (saturated).

Source files
------------

// File: rtl/vip_sobel_pkg.sv
// Shared types and constants for the Sobel frame run controller.
package vip_sobel_pkg;
  localparam int THRESH_W = 11;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_THRESH = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_EDGES  = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    RUN       = 2'd2,
    STOP_PEND = 2'd3
  } state_t;
endpackage

// File: rtl/vip_edge_counter.sv
// Post-detector edge counter: saturating per-frame accumulate, latched and pulsed
// on each detector-output vsync rise.
module vip_edge_counter #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_frame_seen,
  input  logic             i_vsync,
  input  logic             i_href,
  input  logic             i_clken,
  input  logic             i_bit,
  output logic [CNT_W-1:0] o_edge_last,
  output logic             o_frame_done
);
  logic             r_vs_q;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_last;
  logic             r_done;
  logic             w_hit;
  logic             w_rise;
  logic [CNT_W-1:0] w_acc_inc;
  logic             w_suppress;

  assign w_hit      = i_clken & i_href & i_bit;
  assign w_rise     = i_vsync & ~r_vs_q;
  assign w_acc_inc  = (w_hit && (r_acc != '1)) ? r_acc + CNT_W'(1) : r_acc;
  // Nothing to report before any frame has gone through and nothing was counted.
  assign w_suppress = (w_acc_inc == '0) & ~i_frame_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_q <= 1'b0;
      r_acc  <= '0;
      r_last <= '0;
      r_done <= 1'b0;
    end else begin
      r_vs_q <= i_vsync;
      if (w_rise) begin
        r_last <= w_acc_inc;
        r_acc  <= '0;
        r_done <= ~w_suppress;
      end else begin
        r_acc  <= w_acc_inc;
        r_done <= 1'b0;
      end
    end
  end

  assign o_edge_last  = r_last;
  assign o_frame_done = r_done;
endmodule

// File: rtl/vip_sobel_frame_ctrl.sv
// Frame-synchronous run controller: gates whole camera frames into the Sobel
// detector, holds the runtime threshold and reports per-frame edge counts.
module vip_sobel_frame_ctrl
  import vip_sobel_pkg::*;
#(
  parameter int THRESH_DEFAULT = 128,
  parameter int CNT_W          = 24,
  parameter int FCNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_wr_en,
  input  logic [1:0]          cfg_addr,
  input  logic [31:0]         cfg_wdata,
  output logic [31:0]         cfg_rdata,
  input  logic                per_frame_vsync,
  input  logic                per_frame_href,
  input  logic                per_frame_clken,
  output logic                det_frame_vsync,
  output logic                det_frame_href,
  output logic                det_frame_clken,
  output logic [THRESH_W-1:0] det_threshold,
  input  logic                post_frame_vsync,
  input  logic                post_frame_href,
  input  logic                post_frame_clken,
  input  logic                post_img_bit,
  output logic                frame_done,
  output logic                busy
);
  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_gate;
  logic                w_gate_nxt;
  logic                r_vs_q;
  logic                r_en;
  logic                r_ss;
  logic                r_seen;
  logic [THRESH_W-1:0] r_shadow;
  logic [FCNT_W-1:0]   r_fcnt;
  logic [CNT_W-1:0]    w_edges;
  logic                w_vs_rise;
  logic                w_open;
  logic                w_clr_en;
  logic                w_wr_ctrl;
  logic                w_wr_thr;
  logic                w_unused;

  assign w_vs_rise = per_frame_vsync & ~r_vs_q;
  assign w_wr_ctrl = cfg_wr_en && (cfg_addr == ADDR_CTRL);
  assign w_wr_thr  = cfg_wr_en && (cfg_addr == ADDR_THRESH);
  assign w_open    = w_vs_rise & w_gate_nxt;
  assign w_unused  = ^cfg_wdata[31:THRESH_W];

  // The gate only ever changes on a camera vsync rise, so frames pass whole.
  always_comb begin
    w_state_nxt = r_state;
    w_gate_nxt  = r_gate;
    w_clr_en    = 1'b0;
    case (r_state)
      IDLE: if (r_en) w_state_nxt = ARM;
      ARM: begin
        if (!r_en) w_state_nxt = IDLE;
        else if (w_vs_rise) begin
          w_state_nxt = RUN;
          w_gate_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (w_vs_rise) begin
          if (!r_en || r_ss) begin
            w_state_nxt = IDLE;
            w_gate_nxt  = 1'b0;
            w_clr_en    = r_ss;
          end
        end else if (!r_en) begin
          w_state_nxt = STOP_PEND;
        end
      end
      STOP_PEND: begin
        if (r_en) w_state_nxt = RUN;
        else if (w_vs_rise) begin
          w_state_nxt = IDLE;
          w_gate_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gate_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_gate          <= 1'b0;
      r_vs_q          <= 1'b0;
      r_en            <= 1'b0;
      r_ss            <= 1'b0;
      r_seen          <= 1'b0;
      r_shadow        <= THRESH_W'(THRESH_DEFAULT);
      r_fcnt          <= '0;
      det_threshold   <= THRESH_W'(THRESH_DEFAULT);
      det_frame_vsync <= 1'b0;
      det_frame_href  <= 1'b0;
      det_frame_clken <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_gate          <= w_gate_nxt;
      r_vs_q          <= per_frame_vsync;
      det_frame_vsync <= per_frame_vsync & w_gate_nxt;
      det_frame_href  <= per_frame_href  & w_gate_nxt;
      det_frame_clken <= per_frame_clken & w_gate_nxt;
      // A host write wins over the single-shot self-clear in the same cycle.
      if (w_wr_ctrl) begin
        r_en <= cfg_wdata[0];
        r_ss <= cfg_wdata[1];
      end else if (w_clr_en) begin
        r_en <= 1'b0;
      end
      if (w_wr_thr) r_shadow <= cfg_wdata[THRESH_W-1:0];
      if (w_open) begin
        det_threshold <= w_wr_thr ? cfg_wdata[THRESH_W-1:0] : r_shadow;
        r_fcnt        <= r_fcnt + FCNT_W'(1);
        r_seen        <= 1'b1;
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_CTRL:   cfg_rdata[1:0] = {r_ss, r_en};
      ADDR_THRESH: cfg_rdata[THRESH_W-1:0] = r_shadow;
      ADDR_STATUS: begin
        cfg_rdata[1:0]         = r_state;
        cfg_rdata[16 +: FCNT_W] = r_fcnt;
      end
      default:     cfg_rdata[CNT_W-1:0] = w_edges;
    endcase
  end

  assign busy = (r_state != IDLE);

  vip_edge_counter #(
    .CNT_W(CNT_W)
  ) u_edge_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_frame_seen(r_seen),
    .i_vsync     (post_frame_vsync),
    .i_href      (post_frame_href),
    .i_clken     (post_frame_clken),
    .i_bit       (post_img_bit),
    .o_edge_last (w_edges),
    .o_frame_done(frame_done)
  );
endmodule

// File: tb/tb_vip_sobel_frame_ctrl.sv
// Directed bench for the Sobel frame run controller, with a narrow-counter
// second instance for edge-count saturation and start-up suppression.
module tb_vip_sobel_frame_ctrl;
  localparam int FLEN = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic [31:0] cfg_rdata;
  logic        per_vs = 1'b0, per_hs = 1'b0, per_ck = 1'b0;
  logic        det_vs, det_hs, det_ck;
  logic [10:0] det_thr;
  logic        post_vs = 1'b0, post_hs = 1'b0, post_ck = 1'b0, post_bit = 1'b0;
  logic        done, busy;

  logic        z = 1'b0;
  logic [31:0] z32 = 32'd0;
  logic [1:0]  s_addr = 2'd3;
  logic [31:0] s_rdata;
  logic        s_unused_vs, s_unused_hs, s_unused_ck, s_unused_busy;
  logic [10:0] s_unused_thr;
  logic        p4_vs = 1'b0, p4_hs = 1'b0, p4_ck = 1'b0, p4_bit = 1'b0;
  logic        s_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vip_sobel_frame_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .per_frame_vsync(per_vs), .per_frame_href(per_hs), .per_frame_clken(per_ck),
    .det_frame_vsync(det_vs), .det_frame_href(det_hs), .det_frame_clken(det_ck),
    .det_threshold(det_thr),
    .post_frame_vsync(post_vs), .post_frame_href(post_hs), .post_frame_clken(post_ck),
    .post_img_bit(post_bit), .frame_done(done), .busy(busy)
  );

  vip_sobel_frame_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_en(z), .cfg_addr(s_addr), .cfg_wdata(z32), .cfg_rdata(s_rdata),
    .per_frame_vsync(z), .per_frame_href(z), .per_frame_clken(z),
    .det_frame_vsync(s_unused_vs), .det_frame_href(s_unused_hs), .det_frame_clken(s_unused_ck),
    .det_threshold(s_unused_thr),
    .post_frame_vsync(p4_vs), .post_frame_href(p4_hs), .post_frame_clken(p4_ck),
    .post_img_bit(p4_bit), .frame_done(s_done), .busy(s_unused_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic vs, input logic hs, input logic ck);
    per_vs = vs; per_hs = hs; per_ck = ck;
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
  endtask

  task automatic rchk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    cfg_addr = addr;
    #1;
    chk(tag, cfg_rdata, exp);
  endtask

  // One camera frame; g is the gate state the frame is expected to see.
  task automatic frame(input logic g,
                       input int wa, input logic [1:0] aa, input logic [31:0] da,
                       input int wb, input logic [1:0] ab, input logic [31:0] db);
    for (int i = 0; i < FLEN; i++) begin
      logic vs, hs, ck;
      vs = (i < 2);
      hs = (i >= 3) && (i < FLEN - 1);
      ck = hs & i[0];
      if (i == wa) begin cfg_wr_en = 1'b1; cfg_addr = aa; cfg_wdata = da; end
      if (i == wb) begin cfg_wr_en = 1'b1; cfg_addr = ab; cfg_wdata = db; end
      cyc(vs, hs, ck);
      chk("det_stream", {29'd0, det_vs, det_hs, det_ck}, {29'd0, vs & g, hs & g, ck & g});
    end
  endtask

  initial begin
    // Reset with camera toggling
    for (int i = 0; i < 4; i++) begin
      cyc(i[0], 1'b1, i[1]);
      chk("det_in_reset", {29'd0, det_vs, det_hs, det_ck}, 32'd0);
    end
    per_vs = 1'b0; per_hs = 1'b0; per_ck = 1'b0;
    #2 rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rchk("rst_ctrl", 2'd0, 32'd0);
    rchk("rst_thresh", 2'd1, 32'd128);
    rchk("rst_status", 2'd2, 32'd0);
    rchk("rst_edges", 2'd3, 32'd0);
    chk("rst_det_thr", 32'(det_thr), 32'd128);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Enable mid-frame: this frame stays closed, next one passes
    frame(1'b0, 5, 2'd0, 32'd1, -1, 2'd0, 32'd0);
    rchk("arm_status", 2'd2, 32'h0000_0001);
    chk("arm_busy", 32'(busy), 32'd1);
    frame(1'b1, 5, 2'd1, 32'd200, -1, 2'd0, 32'd0);
    rchk("run_status", 2'd2, 32'h0001_0002);
    chk("thr_held", 32'(det_thr), 32'd128);
    rchk("shadow_200", 2'd1, 32'd200);
    frame(1'b1, -1, 2'd0, 32'd0, -1, 2'd0, 32'd0);
    chk("thr_applied", 32'(det_thr), 32'd200);
    rchk("status_c", 2'd2, 32'h0002_0002);
    // Threshold write coincident with vsync rise
    frame(1'b1, 0, 2'd1, 32'd250, -1, 2'd0, 32'd0);
    chk("thr_fwd", 32'(det_thr), 32'd250);
    rchk("shadow_250", 2'd1, 32'd250);
    rchk("status_d", 2'd2, 32'h0003_0002);

    // Disable mid-frame: STOP_PEND, frame completes, gate closes at next rise
    frame(1'b1, 5, 2'd0, 32'd0, -1, 2'd0, 32'd0);
    rchk("stop_pend", 2'd2, 32'h0004_0003);
    chk("stop_busy", 32'(busy), 32'd1);
    frame(1'b0, -1, 2'd0, 32'd0, -1, 2'd0, 32'd0);
    rchk("stopped", 2'd2, 32'h0004_0000);
    chk("idle_busy", 32'(busy), 32'd0);

    // Re-enable before frame end keeps the stream running
    frame(1'b0, 5, 2'd0, 32'd1, -1, 2'd0, 32'd0);
    rchk("rearm", 2'd2, 32'h0004_0001);
    frame(1'b1, 3, 2'd0, 32'd0, 7, 2'd0, 32'd1);
    rchk("resume", 2'd2, 32'h0005_0002);
    frame(1'b1, -1, 2'd0, 32'd0, -1, 2'd0, 32'd0);
    rchk("no_gap", 2'd2, 32'h0006_0002);
    frame(1'b1, 3, 2'd0, 32'd0, -1, 2'd0, 32'd0);
    frame(1'b0, -1, 2'd0, 32'd0, -1, 2'd0, 32'd0);
    rchk("idle_again", 2'd2, 32'h0007_0000);

    // Single shot: exactly one frame
    frame(1'b0, 5, 2'd0, 32'd3, -1, 2'd0, 32'd0);
    rchk("ss_arm", 2'd2, 32'h0007_0001);
    frame(1'b1, -1, 2'd0, 32'd0, -1, 2'd0, 32'd0);
    rchk("ss_run", 2'd2, 32'h0008_0002);
    rchk("ss_ctrl_run", 2'd0, 32'd3);
    frame(1'b0, -1, 2'd0, 32'd0, -1, 2'd0, 32'd0);
    rchk("ss_done", 2'd2, 32'h0008_0000);
    rchk("ss_ctrl_clr", 2'd0, 32'd2);
    frame(1'b0, -1, 2'd0, 32'd0, -1, 2'd0, 32'd0);
    rchk("ss_stays", 2'd2, 32'h0008_0000);

    // Read-only registers ignore writes
    cfg_wr_en = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'hFFFF_FFFF;
    cyc(1'b0, 1'b0, 1'b0);
    cfg_wr_en = 1'b1; cfg_addr = 2'd3; cfg_wdata = 32'hFFFF_FFFF;
    cyc(1'b0, 1'b0, 1'b0);
    rchk("ro_status", 2'd2, 32'h0008_0000);
    rchk("ro_edges", 2'd3, 32'd0);

    // Edge counting; the narrow instance has passed no frame yet
    post_vs = 1'b1; p4_vs = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("done_empty", 32'(done), 32'd1);
    chk("sat_suppress", 32'(s_done), 32'd0);
    post_vs = 1'b0; p4_vs = 1'b0;
    for (int i = 0; i < 40; i++) begin
      post_hs = 1'b1; post_ck = 1'b1; post_bit = (i < 37);
      p4_hs = 1'b1; p4_ck = 1'b1; p4_bit = (i < 20);
      cyc(1'b0, 1'b0, 1'b0);
    end
    chk("done_idle", 32'(done), 32'd0);
    post_hs = 1'b0; post_ck = 1'b0; post_bit = 1'b0;
    p4_hs = 1'b0; p4_ck = 1'b0; p4_bit = 1'b0;
    post_vs = 1'b1; p4_vs = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("done_37", 32'(done), 32'd1);
    rchk("edges_37", 2'd3, 32'd37);
    chk("sat_done", 32'(s_done), 32'd1);
    chk("sat_edges", s_rdata, 32'd15);
    post_vs = 1'b0; p4_vs = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("sat_pulse_end", 32'(s_done), 32'd0);
    for (int i = 0; i < 5; i++) begin
      post_hs = 1'b1; post_ck = 1'b1; post_bit = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
    end
    post_vs = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("done_6", 32'(done), 32'd1);
    rchk("edges_rise_hit", 2'd3, 32'd6);
    post_vs = 1'b0; post_hs = 1'b0; post_ck = 1'b0; post_bit = 1'b0;

    // Async reset mid-frame
    frame(1'b0, 5, 2'd0, 32'd1, -1, 2'd0, 32'd0);
    frame(1'b1, -1, 2'd0, 32'd0, -1, 2'd0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("pre_rst_vs", {29'd0, det_vs, det_hs, det_ck}, 32'd4);
    cyc(1'b0, 1'b1, 1'b1);
    chk("pre_rst_px", {29'd0, det_vs, det_hs, det_ck}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_det", {29'd0, det_vs, det_hs, det_ck}, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_thr", 32'(det_thr), 32'd128);
    rchk("arst_status", 2'd2, 32'd0);
    rchk("arst_shadow", 2'd1, 32'd128);
    rchk("arst_edges", 2'd3, 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
